// File: rtl/envia_uart_pkg.sv
// -----------------------------------------------------------------------------
// envia_uart_pkg
// Shared UART framing definitions for the transmit side of the serial link.
// The receiver on the same link uses the same frame constants and state
// encodings, so both ends agree on bit order and line levels.
//
// Contents:
//   DATA_BITS    - payload bits per frame (8, LSB first)
//   START_LEVEL  - line level of the start bit (0)
//   IDLE_LEVEL   - line level when idle and during stop bits (1)
//   txState_t    - transmitter FSM encoding: IDLE, START, DATA, STOP
//   calcDiv()    - clocks per bit, rounded to the nearest integer
// -----------------------------------------------------------------------------
package envia_uart_pkg;

    localparam int   DATA_BITS   = 8;
    localparam logic START_LEVEL = 1'b0;
    localparam logic IDLE_LEVEL  = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } txState_t;

    // Rounded division so that e.g. 50 MHz / 9600 lands on the closest
    // integer divisor instead of always truncating toward a faster baud.
    function automatic int calcDiv(input int clkHz, input int baud);
        return (clkHz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/envia_uart_baud_div.sv
// -----------------------------------------------------------------------------
// uart_baud_div
// Bit-period timer for the UART transmitter. Produces a one-cycle tick every
// DIV clocks while run is high. restart zeroes the count so a new frame always
// starts on a full bit period, regardless of where the previous one ended.
//
// Parameters:
//   DIV      clocks per bit period (>= 1)
// Ports:
//   clk      in   system clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   restart  in   zero the counter on this edge (takes priority over run)
//   run      in   count enable
//   tick     out  high during the last clock of each bit period
// -----------------------------------------------------------------------------
module uart_baud_div
    import envia_uart_pkg::*;
#(
    parameter int DIV = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    input  logic run,
    output logic tick
);

    // A divisor of 1 still needs a one-bit counter to stay legal.
    localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] count;

    assign tick = run && (count == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (restart) begin
            count <= '0;
        end else if (run) begin
            if (tick) begin
                count <= '0;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/envia_uart.sv
// -----------------------------------------------------------------------------
// envia_uart
// UART transmitter, 8 data bits, no parity, 1 or 2 stop bits, LSB first,
// idle-high line. Sits between the SPWM control logic and the TxD pin.
// A one-entry holding register in front of the shifter lets the producer queue
// the next byte while the current frame is on the wire, so back-to-back frames
// leave the pin with no idle gap between the last stop bit and the next start.
//
// Parameters:
//   ClkFrequency  clk frequency in Hz
//   Baud          line rate in bit/s
//   StopBits      1 or 2
// Ports:
//   clk       in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   Tx_start  in   write request, accepted when Tx_start && Tx_ready
//   TxD_data  in   byte to send, captured only on an accepted write
//   Tx_ready  out  holding register empty
//   Tx_busy   out  frame in flight or byte waiting in the holding register
//   Tx_done   out  one-cycle pulse at the end of each frame's last stop bit
//   TxD       out  registered serial line
// -----------------------------------------------------------------------------
module envia_uart
    import envia_uart_pkg::*;
#(
    parameter int ClkFrequency = 50000000,
    parameter int Baud         = 9600,
    parameter int StopBits     = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 Tx_start,
    input  logic [DATA_BITS-1:0] TxD_data,
    output logic                 Tx_ready,
    output logic                 Tx_busy,
    output logic                 Tx_done,
    output logic                 TxD
);

    localparam int   DIV       = calcDiv(ClkFrequency, Baud);
    // Index of the final stop bit; anything other than 2 is treated as 1.
    localparam logic STOP_LAST = (StopBits == 2) ? 1'b1 : 1'b0;
    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    txState_t             state;
    txState_t             stateNext;
    logic                 holdFull;
    logic [DATA_BITS-1:0] holdData;
    logic [DATA_BITS-1:0] shifter;
    logic [DATA_BITS-1:0] shiftNext;
    logic [2:0]           bitIdx;
    logic [2:0]           bitIdxNext;
    logic                 stopCnt;
    logic                 stopCntNext;
    logic                 loadFrame;
    logic                 doneNext;
    logic                 txdNext;
    logic                 accept;
    logic                 baudRun;
    logic                 baudTick;

    // A write is only taken while the holding register is empty. On the edge
    // where the held byte moves into the shifter, holdFull is still set, so a
    // write presented on that same edge is dropped and must be retried.
    assign accept   = Tx_start && !holdFull;
    assign Tx_ready = !holdFull;
    assign Tx_busy  = (state != IDLE) || holdFull;
    assign baudRun  = (state != IDLE);

    uart_baud_div #(
        .DIV(DIV)
    ) uBaud (
        .clk     (clk),
        .rst_n   (rst_n),
        .restart (loadFrame),
        .run     (baudRun),
        .tick    (baudTick)
    );

    // Next-state and datapath steering. Every frame load (from IDLE or straight
    // out of the last stop bit) restarts the bit timer so the start bit gets a
    // full DIV clocks.
    always_comb begin
        stateNext   = state;
        shiftNext   = shifter;
        bitIdxNext  = bitIdx;
        stopCntNext = stopCnt;
        loadFrame   = 1'b0;
        doneNext    = 1'b0;

        case (state)
            IDLE: begin
                if (holdFull) begin
                    loadFrame = 1'b1;
                    shiftNext = holdData;
                    stateNext = START;
                end
            end

            START: begin
                if (baudTick) begin
                    bitIdxNext = '0;
                    stateNext  = DATA;
                end
            end

            DATA: begin
                if (baudTick) begin
                    shiftNext  = {1'b0, shifter[DATA_BITS-1:1]};
                    bitIdxNext = bitIdx + 3'd1;
                    if (bitIdx == LAST_BIT) begin
                        stopCntNext = 1'b0;
                        stateNext   = STOP;
                    end
                end
            end

            STOP: begin
                if (baudTick) begin
                    if (stopCnt == STOP_LAST) begin
                        doneNext = 1'b1;
                        if (holdFull) begin
                            // Chain straight into the next frame's start bit.
                            loadFrame = 1'b1;
                            shiftNext = holdData;
                            stateNext = START;
                        end else begin
                            stateNext = IDLE;
                        end
                    end else begin
                        stopCntNext = stopCnt + 1'b1;
                    end
                end
            end

            default: begin
                stateNext = IDLE;
            end
        endcase

        // TxD is registered, so its next value follows the state being entered;
        // this keeps the pin glitch-free and aligned with the state change.
        case (stateNext)
            START:   txdNext = START_LEVEL;
            DATA:    txdNext = shiftNext[0];
            default: txdNext = IDLE_LEVEL;
        endcase
    end

    // Control registers: reset returns the line to idle immediately and
    // discards both the frame in flight and any held byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            holdFull <= 1'b0;
            bitIdx   <= '0;
            stopCnt  <= 1'b0;
            TxD      <= IDLE_LEVEL;
            Tx_done  <= 1'b0;
        end else begin
            state    <= stateNext;
            bitIdx   <= bitIdxNext;
            stopCnt  <= stopCntNext;
            TxD      <= txdNext;
            Tx_done  <= doneNext;
            if (accept) begin
                holdFull <= 1'b1;
            end else if (loadFrame) begin
                holdFull <= 1'b0;
            end
        end
    end

    // Data registers carry no reset: their contents are only observed after a
    // load, which always follows an accepted write.
    always_ff @(posedge clk) begin
        if (accept) begin
            holdData <= TxD_data;
        end
        shifter <= shiftNext;
    end

endmodule

// File: tb/tb_envia_uart.sv
// -----------------------------------------------------------------------------
// tb_envia_uart
// Directed bench for envia_uart at 1 MHz / 100 kBd (10 clocks per bit).
// dut1 uses one stop bit, dut2 uses two. Expected line patterns are written
// out in wire order (start, b0..b7, stop[s]).
// -----------------------------------------------------------------------------
module tb_envia_uart;

    typedef struct {
        logic [7:0] data;
        logic [0:9] seq;
    } frame_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start1, start2;
    logic [7:0] data1, data2;
    logic       ready1, busy1, done1, txd1;
    logic       ready2, busy2, done2, txd2;

    int checks = 0;
    int errors = 0;

    frame_t frames [4];

    always #5 clk = ~clk;

    envia_uart #(
        .ClkFrequency (1000000),
        .Baud         (100000),
        .StopBits     (1)
    ) dut1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .Tx_start (start1),
        .TxD_data (data1),
        .Tx_ready (ready1),
        .Tx_busy  (busy1),
        .Tx_done  (done1),
        .TxD      (txd1)
    );

    envia_uart #(
        .ClkFrequency (1000000),
        .Baud         (100000),
        .StopBits     (2)
    ) dut2 (
        .clk      (clk),
        .rst_n    (rst_n),
        .Tx_start (start2),
        .TxD_data (data2),
        .Tx_ready (ready2),
        .Tx_busy  (busy2),
        .Tx_done  (done2),
        .TxD      (txd2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Walks the line from cycle i0 (cycle 0 = just after the start-bit edge),
    // checking every cycle's level and that Tx_done fires only on frame
    // boundaries. Ends on the edge after the last stop bit.
    task automatic checkStream(input bit two, input logic [0:39] seq,
                               input int nBits, input int i0, input string tag);
        int frameLen;
        frameLen = two ? 110 : 100;
        for (int i = i0; i < nBits * 10; i++) begin
            chk({tag, " txd"}, two ? int'(txd2) : int'(txd1), int'(seq[i / 10]));
            chk({tag, " done"}, two ? int'(done2) : int'(done1),
                (i > 0 && (i % frameLen) == 0) ? 1 : 0);
            step();
        end
        chk({tag, " final done"}, two ? int'(done2) : int'(done1), 1);
        chk({tag, " final txd"},  two ? int'(txd2)  : int'(txd1),  1);
        chk({tag, " final busy"}, two ? int'(busy2) : int'(busy1), 0);
    endtask

    initial begin
        frames[0] = '{8'hA5, 10'b0101001011};
        frames[1] = '{8'h3C, 10'b0001111001};
        frames[2] = '{8'h01, 10'b0100000001};
        frames[3] = '{8'hFE, 10'b0011111111};

        rst_n  = 1'b0;
        start1 = 1'b0;
        start2 = 1'b0;
        data1  = 8'h00;
        data2  = 8'h00;

        // Reset state
        repeat (3) step();
        chk("rst txd1",   txd1,   1);
        chk("rst ready1", ready1, 1);
        chk("rst busy1",  busy1,  0);
        chk("rst done1",  done1,  0);
        chk("rst txd2",   txd2,   1);
        chk("rst ready2", ready2, 1);
        rst_n = 1'b1;
        for (int c = 0; c < 200; c++) begin
            step();
            chk("idle txd1", txd1, 1);
            chk("idle busy1", busy1, 0);
        end

        // Single frames from the table
        for (int k = 0; k < 4; k++) begin
            start1 = 1'b1;
            data1  = frames[k].data;
            step();
            chk("accept ready", ready1, 0);
            chk("accept busy",  busy1,  1);
            chk("accept txd",   txd1,   1);
            start1 = 1'b0;
            data1  = ~frames[k].data;
            step();
            chk("start latency txd", txd1, 0);
            chk("ready after load",  ready1, 1);
            checkStream(1'b0, {frames[k].seq, 30'b0}, 10, 0, "frame");
            step();
            chk("done one cycle", done1, 0);
            repeat (5) step();
        end

        // Back-to-back 00 then FF
        start1 = 1'b1;
        data1  = 8'h00;
        step();
        start1 = 1'b0;
        step();
        chk("b2b start txd", txd1, 0);
        start1 = 1'b1;
        data1  = 8'hFF;
        step();
        chk("b2b second held", ready1, 0);
        start1 = 1'b0;
        checkStream(1'b0, {10'b0000000001, 10'b0111111111, 20'b0}, 20, 1, "b2b");
        step();
        repeat (5) step();

        // Overrun: 11 accepted, 22 dropped, 33 accepted
        start1 = 1'b1;
        data1  = 8'h11;
        step();
        chk("ovr 11 held", ready1, 0);
        data1 = 8'h22;
        step();
        chk("ovr ready again", ready1, 1);
        chk("ovr start txd",   txd1,   0);
        data1 = 8'h33;
        step();
        chk("ovr 33 held", ready1, 0);
        start1 = 1'b0;
        checkStream(1'b0, {10'b0100010001, 10'b0110011001, 20'b0}, 20, 1, "overrun");
        step();
        repeat (5) step();

        // Two stop bits, byte 80
        start2 = 1'b1;
        data2  = 8'h80;
        step();
        start2 = 1'b0;
        step();
        chk("stop2 start txd", txd2, 0);
        checkStream(1'b1, {11'b00000000111, 29'b0}, 11, 0, "stop2");
        step();
        chk("stop2 done one cycle", done2, 0);

        // Reset mid-frame with a byte held
        start1 = 1'b1;
        data1  = 8'h52;
        step();
        start1 = 1'b0;
        step();
        start1 = 1'b1;
        data1  = 8'hC3;
        step();
        chk("midrst held", ready1, 0);
        start1 = 1'b0;
        repeat (44) step();
        chk("midrst pre txd", txd1, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst txd async",   txd1,   1);
        chk("midrst ready",       ready1, 1);
        chk("midrst busy",        busy1,  0);
        chk("midrst done",        done1,  0);
        repeat (3) step();
        rst_n = 1'b1;
        for (int c = 0; c < 300; c++) begin
            step();
            chk("post rst txd",  txd1,  1);
            chk("post rst done", done1, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
